// File: rtl/trap_pkg.sv
// Shared types and constants for the commit-stage trap sequencer.
package trap_pkg;

  typedef enum logic [1:0] {StIdle, StTrap, StRet, StRedirect} trap_state_e;

  localparam logic [11:0] CsrMtvec  = 12'h305;
  localparam logic [11:0] CsrMepc   = 12'h341;
  localparam logic [11:0] CsrMcause = 12'h342;
  localparam logic [11:0] CsrMtval  = 12'h343;

  localparam logic [3:0] ExcInstrMisaligned = 4'd0;
  localparam logic [3:0] ExcInstrFault      = 4'd1;
  localparam logic [3:0] ExcIllegal         = 4'd2;
  localparam logic [3:0] ExcBreakpoint      = 4'd3;
  localparam logic [3:0] ExcLoadMisaligned  = 4'd4;
  localparam logic [3:0] ExcLoadFault       = 4'd5;
  localparam logic [3:0] ExcStoreMisaligned = 4'd6;
  localparam logic [3:0] ExcStoreFault      = 4'd7;
  localparam logic [3:0] ExcEcallU          = 4'd8;
  localparam logic [3:0] ExcEcallS          = 4'd9;
  localparam logic [3:0] ExcEcallM          = 4'd11;
  localparam logic [3:0] ExcInstrPageFault  = 4'd12;
  localparam logic [3:0] ExcLoadPageFault   = 4'd13;
  localparam logic [3:0] ExcStorePageFault  = 4'd15;

  localparam logic [3:0] IntMsi = 4'd3;
  localparam logic [3:0] IntMti = 4'd7;
  localparam logic [3:0] IntMei = 4'd11;

  // Index 0 is the highest-priority exception code.
  localparam logic [3:0] ExcPrio [16] = '{
    ExcBreakpoint, ExcInstrPageFault, ExcInstrFault, ExcInstrMisaligned,
    ExcIllegal, ExcEcallU, ExcEcallS, ExcEcallM,
    ExcStoreMisaligned, ExcLoadMisaligned, ExcStorePageFault, ExcLoadPageFault,
    ExcStoreFault, ExcLoadFault, 4'd10, 4'd14
  };

  typedef struct packed {
    logic       valid;
    logic       is_int;
    logic [3:0] code;
  } trap_cause_t;

  function automatic logic [15:0] onehot16(input logic [3:0] code);
    return 16'(1) << code;
  endfunction

endpackage

// File: rtl/trap_controller_if.sv
// Commit, CSR and redirect signals between the commit stage and the trap sequencer.
interface trap_controller_if #(
  parameter int unsigned N = 64
);
  logic          commitValid;
  logic [N-1:0]  commitPC;
  logic [15:0]   excVector;
  logic [N-1:0]  excTval;
  logic          mretCommit;
  logic [2:0]    mip;
  logic [2:0]    mie;
  logic          mstatusMIE;
  logic          csrWe;
  logic [11:0]   csrAddr;
  logic [N-1:0]  csrWdata;
  logic          fetchReady;
  logic [15:0]   trapTrigger;
  logic          trapReturn;
  logic          flush;
  logic          pcRedirect;
  logic [N-1:0]  pcTarget;
  logic          stall;
  logic [N-1:0]  csrRdata;

  modport master (
    output commitValid, commitPC, excVector, excTval, mretCommit, mip, mie, mstatusMIE,
    output csrWe, csrAddr, csrWdata, fetchReady,
    input  trapTrigger, trapReturn, flush, pcRedirect, pcTarget, stall, csrRdata
  );

  modport slave (
    input  commitValid, commitPC, excVector, excTval, mretCommit, mip, mie, mstatusMIE,
    input  csrWe, csrAddr, csrWdata, fetchReady,
    output trapTrigger, trapReturn, flush, pcRedirect, pcTarget, stall, csrRdata
  );
endinterface

// File: rtl/flopre_init.sv
// Register with synchronous reset to a parameterised value and load enable.
module flopre_init #(
  parameter int unsigned      Width = 64,
  parameter logic [Width-1:0] Init  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= Init;
    end else if (en) begin
      q <= d;
    end
  end
endmodule

// File: rtl/trap_cause_arbiter.sv
// Picks the single trap cause at commit: any exception beats any interrupt.
module trap_cause_arbiter
  import trap_pkg::*;
(
  input  logic [15:0] exc_vector,
  input  logic [2:0]  irq_pending,
  input  logic        global_ie,
  output trap_cause_t cause
);
  logic found;

  always_comb begin
    cause = '0;
    found = 1'b0;
    if (exc_vector != 16'h0) begin
      cause.valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (!found && exc_vector[ExcPrio[4'(i)]]) begin
          found      = 1'b1;
          cause.code = ExcPrio[4'(i)];
        end
      end
    end else if (global_ie && (irq_pending != 3'b000)) begin
      cause.valid  = 1'b1;
      cause.is_int = 1'b1;
      // irq_pending is {MEI, MTI, MSI}; MSI outranks MTI.
      if (irq_pending[2]) begin
        cause.code = IntMei;
      end else if (irq_pending[0]) begin
        cause.code = IntMsi;
      end else begin
        cause.code = IntMti;
      end
    end
  end
endmodule

// File: rtl/trap_controller.sv
// Commit-stage trap/MRET sequencer: emits cause pulses, owns the trap CSRs and redirects fetch.
module trap_controller
  import trap_pkg::*;
#(
  parameter int unsigned  N           = 64,
  parameter logic [N-1:0] MTVEC_RESET = '0
) (
  input logic              clk,
  input logic              reset,
  trap_controller_if.slave bus
);
  trap_state_e state_q;
  trap_cause_t cause;
  logic [15:0] trig_q;
  logic        ret_q, flush_q, redirect_q, is_int_q;
  logic [3:0]  code_q;
  logic [N-1:0] target_q, trap_target, base;
  logic [N-1:0] mtvec_q, mepc_q, mcause_q, mtval_q;
  logic [N-1:0] mepc_d, mcause_d, mtval_d;
  logic         mtvec_en, mepc_en, mcause_en, mtval_en;
  logic         take_trap, csr_wr;

  trap_cause_arbiter u_arbiter (
    .exc_vector (bus.excVector),
    .irq_pending(bus.mip & bus.mie),
    .global_ie  (bus.mstatusMIE),
    .cause      (cause)
  );

  assign take_trap = (state_q == StIdle) && bus.commitValid && cause.valid;
  assign csr_wr    = (state_q == StIdle) && bus.csrWe && !take_trap;

  always_comb begin
    mtvec_en  = csr_wr && (bus.csrAddr == CsrMtvec);
    mepc_en   = take_trap || (csr_wr && (bus.csrAddr == CsrMepc));
    mcause_en = take_trap || (csr_wr && (bus.csrAddr == CsrMcause));
    mtval_en  = take_trap || (csr_wr && (bus.csrAddr == CsrMtval));
    mepc_d    = take_trap ? {bus.commitPC[N-1:2], 2'b00} : {bus.csrWdata[N-1:2], 2'b00};
    mcause_d  = take_trap ? {cause.is_int, {(N-5){1'b0}}, cause.code} : bus.csrWdata;
    mtval_d   = bus.csrWdata;
    if (take_trap) begin
      mtval_d = cause.is_int ? '0 : bus.excTval;
    end
  end

  flopre_init #(.Width(N), .Init(MTVEC_RESET)) u_mtvec (
    .clk(clk), .reset(reset), .en(mtvec_en), .d(bus.csrWdata), .q(mtvec_q)
  );
  flopre_init #(.Width(N), .Init('0)) u_mepc (
    .clk(clk), .reset(reset), .en(mepc_en), .d(mepc_d), .q(mepc_q)
  );
  flopre_init #(.Width(N), .Init('0)) u_mcause (
    .clk(clk), .reset(reset), .en(mcause_en), .d(mcause_d), .q(mcause_q)
  );
  flopre_init #(.Width(N), .Init('0)) u_mtval (
    .clk(clk), .reset(reset), .en(mtval_en), .d(mtval_d), .q(mtval_q)
  );

  // Mode 2'b1x is stored as written but behaves as direct.
  assign base        = {mtvec_q[N-1:2], 2'b00};
  assign trap_target = ((mtvec_q[1:0] == 2'b01) && is_int_q) ?
                       base + {{(N-6){1'b0}}, code_q, 2'b00} : base;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      trig_q     <= '0;
      ret_q      <= 1'b0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      target_q   <= '0;
      is_int_q   <= 1'b0;
      code_q     <= '0;
    end else begin
      trig_q  <= '0;
      ret_q   <= 1'b0;
      flush_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (take_trap) begin
            state_q  <= StTrap;
            trig_q   <= onehot16(cause.code);
            flush_q  <= 1'b1;
            is_int_q <= cause.is_int;
            code_q   <= cause.code;
          end else if (bus.commitValid && bus.mretCommit) begin
            state_q <= StRet;
            ret_q   <= 1'b1;
            flush_q <= 1'b1;
          end
        end
        StTrap: begin
          state_q    <= StRedirect;
          redirect_q <= 1'b1;
          target_q   <= trap_target;
        end
        StRet: begin
          state_q    <= StRedirect;
          redirect_q <= 1'b1;
          target_q   <= mepc_q;
        end
        StRedirect: begin
          if (bus.fetchReady) begin
            state_q    <= StIdle;
            redirect_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.trapTrigger = trig_q;
  assign bus.trapReturn  = ret_q;
  assign bus.flush       = flush_q;
  assign bus.pcRedirect  = redirect_q;
  assign bus.pcTarget    = target_q;
  assign bus.stall       = (state_q != StIdle);

  always_comb begin
    case (bus.csrAddr)
      CsrMtvec:   bus.csrRdata = mtvec_q;
      CsrMepc:    bus.csrRdata = mepc_q;
      CsrMcause:  bus.csrRdata = mcause_q;
      CsrMtval:   bus.csrRdata = mtval_q;
      default:    bus.csrRdata = '0;
    endcase
  end
endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: vector table of single events plus multi-cycle sequences.
module tb_trap_controller;
  localparam logic [63:0] MtvecInit = 64'h100;
  localparam logic [11:0] AMtvec = 12'h305, AMepc = 12'h341, AMcause = 12'h342, AMtval = 12'h343;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  trap_controller_if #(.N(64)) bus ();

  trap_controller #(.N(64), .MTVEC_RESET(MtvecInit)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] mtvec;
    logic [15:0] exc;
    logic [2:0]  mip;
    logic [2:0]  mie;
    logic        mstat;
    logic        mret;
    logic [63:0] pc;
    logic [63:0] tval;
    logic [15:0] trig;
    logic        ret;
    logic [63:0] cause;
    logic [63:0] mepc;
    logic [63:0] mtval;
    logic [63:0] target;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic read_csr(input logic [11:0] addr, output logic [63:0] val);
    bus.csrAddr = addr;
    #1;
    val = bus.csrRdata;
  endtask

  task automatic write_csr(input logic [11:0] addr, input logic [63:0] data);
    bus.csrWe    = 1'b1;
    bus.csrAddr  = addr;
    bus.csrWdata = data;
    @(negedge clk);
    bus.csrWe = 1'b0;
  endtask

  task automatic clear_commit();
    bus.commitValid = 1'b0;
    bus.excVector   = '0;
    bus.mretCommit  = 1'b0;
    bus.mip         = '0;
    bus.mie         = '0;
    bus.mstatusMIE  = 1'b0;
  endtask

  initial begin
    logic [63:0] rd;
    logic        ev;

    clear_commit();
    bus.commitPC = '0;
    bus.excTval = '0;
    bus.csrWe = 1'b0;
    bus.csrAddr = '0;
    bus.csrWdata = '0;
    bus.fetchReady = 1'b0;

    //          mtvec     exc      mip     mie     ms    mret  pc        tval
    //          trig      ret   cause                  mepc      mtval     target
    vecs[0]  = '{64'h8000, 16'h0004, 3'b000, 3'b000, 1'b0, 1'b0, 64'h1000, 64'hDEAD,
                 16'h0004, 1'b0, 64'd2, 64'h1000, 64'hDEAD, 64'h8000};
    vecs[1]  = '{64'h8001, 16'h0000, 3'b010, 3'b010, 1'b1, 1'b0, 64'h2004, 64'h55,
                 16'h0080, 1'b0, 64'h8000_0000_0000_0007, 64'h2004, 64'h0, 64'h801C};
    vecs[2]  = '{64'h8001, 16'h0000, 3'b111, 3'b111, 1'b1, 1'b0, 64'h2006, 64'h55,
                 16'h0800, 1'b0, 64'h8000_0000_0000_000B, 64'h2004, 64'h0, 64'h802C};
    vecs[3]  = '{64'h8003, 16'h0000, 3'b001, 3'b001, 1'b1, 1'b0, 64'h2010, 64'h0,
                 16'h0008, 1'b0, 64'h8000_0000_0000_0003, 64'h2010, 64'h0, 64'h8000};
    vecs[4]  = '{64'h8001, 16'h1002, 3'b111, 3'b111, 1'b1, 1'b0, 64'h1100, 64'hBEEF,
                 16'h1000, 1'b0, 64'd12, 64'h1100, 64'hBEEF, 64'h8000};
    vecs[5]  = '{64'h8000, 16'h0900, 3'b000, 3'b000, 1'b0, 1'b1, 64'h1200, 64'h77,
                 16'h0100, 1'b0, 64'd8, 64'h1200, 64'h77, 64'h8000};
    vecs[6]  = '{64'h8000, 16'hC000, 3'b000, 3'b000, 1'b0, 1'b0, 64'h1300, 64'h88,
                 16'h8000, 1'b0, 64'd15, 64'h1300, 64'h88, 64'h8000};
    vecs[7]  = '{64'h8000, 16'h4400, 3'b000, 3'b000, 1'b0, 1'b0, 64'h1400, 64'h99,
                 16'h0400, 1'b0, 64'd10, 64'h1400, 64'h99, 64'h8000};
    vecs[8]  = '{64'h8000, 16'h0000, 3'b000, 3'b000, 1'b0, 1'b1, 64'h1500, 64'h0,
                 16'h0000, 1'b1, 64'd0, 64'h3000, 64'h0, 64'h3000};
    vecs[9]  = '{64'h8000, 16'hFFFF, 3'b000, 3'b000, 1'b0, 1'b0, 64'h1600, 64'hAA,
                 16'h0008, 1'b0, 64'd3, 64'h1600, 64'hAA, 64'h8000};
    vecs[10] = '{64'h8000, 16'h0000, 3'b101, 3'b010, 1'b1, 1'b0, 64'h1700, 64'h0,
                 16'h0000, 1'b0, 64'd0, 64'h3000, 64'h0, 64'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst trapTrigger", 64'(bus.trapTrigger), 64'h0);
    check("rst trapReturn", 64'(bus.trapReturn), 64'h0);
    check("rst flush", 64'(bus.flush), 64'h0);
    check("rst pcRedirect", 64'(bus.pcRedirect), 64'h0);
    check("rst stall", 64'(bus.stall), 64'h0);
    read_csr(AMtvec, rd);  check("rst mtvec", rd, MtvecInit);
    read_csr(AMepc, rd);   check("rst mepc", rd, 64'h0);
    read_csr(AMcause, rd); check("rst mcause", rd, 64'h0);
    read_csr(AMtval, rd);  check("rst mtval", rd, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // CSR basics: mepc low bits forced clear, unknown address reads zero
    write_csr(AMepc, 64'h3003);
    read_csr(AMepc, rd);    check("mepc align", rd, 64'h3000);
    read_csr(12'h300, rd);  check("unknown csr", rd, 64'h0);

    for (int i = 0; i < 11; i++) begin
      write_csr(AMtvec, vecs[i].mtvec);
      write_csr(AMepc, 64'h3000);
      bus.commitValid = 1'b1;
      bus.excVector   = vecs[i].exc;
      bus.mip         = vecs[i].mip;
      bus.mie         = vecs[i].mie;
      bus.mstatusMIE  = vecs[i].mstat;
      bus.mretCommit  = vecs[i].mret;
      bus.commitPC    = vecs[i].pc;
      bus.excTval     = vecs[i].tval;
      @(negedge clk);
      clear_commit();
      ev = (vecs[i].trig != 16'h0) || vecs[i].ret;
      check($sformatf("v%0d trapTrigger", i), 64'(bus.trapTrigger), 64'(vecs[i].trig));
      check($sformatf("v%0d trapReturn", i), 64'(bus.trapReturn), 64'(vecs[i].ret));
      check($sformatf("v%0d flush", i), 64'(bus.flush), 64'(ev));
      check($sformatf("v%0d stall", i), 64'(bus.stall), 64'(ev));
      if (ev) begin
        read_csr(AMepc, rd); check($sformatf("v%0d mepc", i), rd, vecs[i].mepc);
        if (vecs[i].trig != 16'h0) begin
          read_csr(AMcause, rd); check($sformatf("v%0d mcause", i), rd, vecs[i].cause);
          read_csr(AMtval, rd);  check($sformatf("v%0d mtval", i), rd, vecs[i].mtval);
        end
        @(negedge clk);
        check($sformatf("v%0d pcRedirect", i), 64'(bus.pcRedirect), 64'h1);
        check($sformatf("v%0d pcTarget", i), bus.pcTarget, vecs[i].target);
        check($sformatf("v%0d pulse end", i), 64'(bus.trapTrigger) | 64'(bus.trapReturn), 64'h0);
        bus.fetchReady = 1'b1;
        @(negedge clk);
        bus.fetchReady = 1'b0;
        check($sformatf("v%0d released", i), 64'(bus.pcRedirect), 64'h0);
        check($sformatf("v%0d stall off", i), 64'(bus.stall), 64'h0);
      end
    end

    // Masked interrupts for 10 cycles
    bus.commitValid = 1'b1;
    bus.mip = 3'b111;
    bus.mie = 3'b111;
    bus.mstatusMIE = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("masked trig c%0d", c), 64'(bus.trapTrigger), 64'h0);
      check($sformatf("masked stall c%0d", c), 64'(bus.stall), 64'h0);
    end
    clear_commit();

    // MRET with held redirect; commits during REDIRECT are ignored
    write_csr(AMepc, 64'h3000);
    bus.commitValid = 1'b1;
    bus.mretCommit  = 1'b1;
    @(negedge clk);
    clear_commit();
    check("mret pulse", 64'(bus.trapReturn), 64'h1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("mret ret low c%0d", c), 64'(bus.trapReturn), 64'h0);
      check($sformatf("mret hold redirect c%0d", c), 64'(bus.pcRedirect), 64'h1);
      check($sformatf("mret hold target c%0d", c), bus.pcTarget, 64'h3000);
      check($sformatf("mret ignore c%0d", c), 64'(bus.trapTrigger), 64'h0);
      bus.commitValid = 1'b1;
      bus.excVector = 16'h0004;
    end
    clear_commit();
    bus.fetchReady = 1'b1;
    @(negedge clk);
    bus.fetchReady = 1'b0;
    check("mret released", 64'(bus.pcRedirect), 64'h0);

    // Trap beats same-cycle CSR write; CSR writes outside IDLE are dropped
    write_csr(AMtvec, 64'h8000);
    bus.commitValid = 1'b1;
    bus.excVector = 16'h0004;
    bus.commitPC = 64'h4000;
    bus.csrWe = 1'b1;
    bus.csrAddr = AMepc;
    bus.csrWdata = 64'h9990;
    @(negedge clk);
    clear_commit();
    read_csr(AMepc, rd); check("trap over csrWe", rd, 64'h4000);
    bus.csrAddr = AMtvec;
    bus.csrWdata = 64'h7770;
    @(negedge clk);
    bus.csrWe = 1'b0;
    read_csr(AMtvec, rd); check("csrWe busy dropped", rd, 64'h8000);

    // Reset while in REDIRECT
    check("pre-reset redirect", 64'(bus.pcRedirect), 64'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset redirect", 64'(bus.pcRedirect), 64'h0);
    check("reset stall", 64'(bus.stall), 64'h0);
    check("reset target", bus.pcTarget, 64'h0);
    read_csr(AMtvec, rd); check("reset mtvec", rd, MtvecInit);
    read_csr(AMepc, rd);  check("reset mepc", rd, 64'h0);
    @(negedge clk);
    check("post-reset trig", 64'(bus.trapTrigger), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
